spi_master_shifter: RTL
=======================

Name: spi_master_shifter

Overview:
- Transfer controller and data shifter for the multi-slave SPI master. It sits directly downstream of the serial-clock generator.
- Drives the generator's nextstate enable, watches the returned sclk for edges in the sys_clock domain, and shifts MOSI out and MISO in, MSB first.
- Handles chip-select decode for the selected slave.
- Presents a simple start/busy/rx_valid interface to the register/control layer.

Parameters:
- DATA_WIDTH, 8, bits per transfer (≥2).
- NUM_SLAVES, 4, number of chip-select outputs.
- SEL_WIDTH, 2, width of slave_sel; must satisfy 2**SEL_WIDTH ≥ NUM_SLAVES.

Ports:
- sys_clock, input, 1, system clock; all logic is rising-edge.
- reset_n, input, 1, asynchronous active-low reset.
- tx_start, input, 1, single-cycle request to start a transfer; honoured only in IDLE.
- tx_data, input, DATA_WIDTH, word to transmit; captured on an accepted tx_start.
- slave_sel, input, SEL_WIDTH, target slave index; captured on an accepted tx_start.
- clock_mode, input, 2, [1]=CPOL, [0]=CPHA; captured on an accepted tx_start; must be held stable while busy because it is shared with the generator.
- sclk, input, 1, serial clock from the generator.
- miso, input, 1, serial data from the selected slave.
- nextstate, output, 1, enable to the clock generator; high only in XFER.
- mosi, output, 1, serial data to the slaves.
- cs_n, output, NUM_SLAVES, active-low chip selects; at most one low.
- busy, output, 1, high from the cycle after an accepted start until return to IDLE.
- rx_data, output, DATA_WIDTH, last received word; holds until the next DONE.
- rx_valid, output, 1, one-cycle pulse in DONE.

Behaviour:
- Reset (asynchronous): state=IDLE, nextstate=0, mosi=0, cs_n=all 1, busy=0, rx_data=0, rx_valid=0, edge counter=0, sclk_q=CPOL of clock_mode.
- Edge detect:
  - sclk_q registers sclk every cycle.
  - edge = (sclk != sclk_q), counted only in XFER.
  - The edge index e runs 1..2*DATA_WIDTH. Odd e = leading edge, even e = trailing edge, for every mode.
- FSM states: IDLE, SETUP, XFER, DONE.
- IDLE:
  - tx_start=1 and slave_sel < NUM_SLAVES → SETUP.
  - On that transition: latch mode, load tx_shift=tx_data, clear rx_shift and the counter.
  - tx_start with slave_sel ≥ NUM_SLAVES is ignored and the block stays in IDLE.
- SETUP (1 cycle):
  - cs_n[sel]=0, busy=1, mosi=tx_shift[MSB] in both modes.
  - nextstate stays 0.
  - → XFER.
- XFER:
  - nextstate=1.
  - CPHA=0: on odd e, rx_shift ← {rx_shift[W-2:0], miso}. On even e with e<2W, tx_shift ← tx_shift<<1.
  - CPHA=1: on odd e with e>1, tx_shift ← tx_shift<<1. On even e, sample miso as above.
  - mosi = tx_shift[MSB] at all times in SETUP/XFER.
  - On edge e=2W, the next state is DONE. sclk is then back at its idle level.
- DONE (1 cycle):
  - nextstate=0.
  - rx_data ← rx_shift and rx_valid=1.
  - cs_n[sel] remains 0 and busy=1.
  - → IDLE.
- After DONE: next cycle cs_n=all 1, busy=0, mosi=0. A new tx_start is accepted in that same IDLE cycle.
- Events ignored or without effect:
  - tx_start while busy is ignored with no queueing.
  - Edges seen outside XFER are not counted.
  - The generator's divide ratio has no effect on correctness: the block simply waits for edges.
- Reset mid-transfer: immediate return to reset values and no rx_valid. The generator resets sclk via the same reset_n.
- Counter width: clog2(2*DATA_WIDTH+1) bits; no wrap inside a transfer.

Test Plan:
1. Mode 0, CLOCK2, tx_data=8'hA5, slave_sel=0, miso looped to mosi → exactly 16 sclk edges (8 rising). rx_data=8'hA5, one rx_valid pulse. cs_n=4'b1110 throughout busy, then 4'b1111.
2. Mode 3, CLOCK16, tx_data=8'h3C, miso tied 1 → mosi bit sequence 0,0,1,1,1,1,0,0 sampled on rising edges. rx_data=8'hFF. sclk idles high before and after.
3. Mode 1, slave model shifting 8'h5A on leading edges, slave_sel=2 → rx_data=8'h5A, cs_n=4'b1011. The first mosi change occurs on edge 3.
4. Mode 0 transfer active; tx_start pulsed at edge 5 with tx_data=8'h00 → ignored. The first transfer completes with its original data and exactly one rx_valid.
5. reset_n low at edge 7 of a mode 2 transfer → cs_n=4'b1111, nextstate=0, busy=0, rx_valid never asserted. sclk=1 after reset. A new transfer of 8'hC3 then completes correctly.
6. Back-to-back: tx_start asserted in the first IDLE cycle after DONE → second transfer starts (SETUP the next cycle) and both rx_valid pulses occur with correct rx_data.

Source files
------------

// File: rtl/spi_master_shifter.sv
// SPI master transfer controller: counts sclk edges from the clock generator,
// shifts MOSI out and MISO in MSB first, and decodes the chip selects.
module spi_master_shifter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                  sys_clock,
    input  logic                  reset_n,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [SEL_WIDTH-1:0]  slave_sel,
    input  logic [1:0]            clock_mode,
    input  logic                  sclk,
    input  logic                  miso,
    output logic                  nextstate,
    output logic                  mosi,
    output logic [NUM_SLAVES-1:0] cs_n,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, XFER = 2'd2, DONE = 2'd3} state_t;

    localparam int CW = $clog2(2*DATA_WIDTH+1);
    localparam logic [CW-1:0] LAST_EDGE = CW'(2*DATA_WIDTH);
    localparam logic [CW-1:0] FIRST_EDGE = CW'(1);

    state_t                state;
    logic [1:0]            mode_q;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [CW-1:0]         edge_cnt;
    logic                  sclk_q;

    logic                  sclk_edge;
    logic [CW-1:0]         edge_idx;
    logic                  edge_odd;
    logic                  sample_now;
    logic                  shift_now;
    logic                  sel_ok;
    logic [DATA_WIDTH-1:0] rx_next;

    assign sclk_edge = (sclk != sclk_q);
    assign edge_idx  = edge_cnt + FIRST_EDGE;
    assign edge_odd  = edge_idx[0];
    assign sel_ok    = (int'(slave_sel) < NUM_SLAVES);
    assign rx_next   = {rx_shift[DATA_WIDTH-2:0], miso};

    // CPHA=0 samples on leading edges and shifts on trailing ones; CPHA=1 is the mirror,
    // skipping the very first leading edge so the MSB stays on the line for one full bit.
    assign sample_now = mode_q[0] ? ~edge_odd : edge_odd;
    assign shift_now  = mode_q[0] ? (edge_odd && edge_idx != FIRST_EDGE)
                                  : (~edge_odd && edge_idx != LAST_EDGE);

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            mode_q   <= 2'b00;
            sel_q    <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            edge_cnt <= '0;
            sclk_q   <= clock_mode[1];
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            sclk_q   <= sclk;
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start && sel_ok) begin
                        state    <= SETUP;
                        mode_q   <= clock_mode;
                        sel_q    <= slave_sel;
                        tx_shift <= tx_data;
                        rx_shift <= '0;
                        edge_cnt <= '0;
                    end
                end
                SETUP: state <= XFER;
                XFER: begin
                    if (sclk_edge) begin
                        edge_cnt <= edge_idx;
                        if (sample_now) rx_shift <= rx_next;
                        if (shift_now) tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                        // The final edge may itself be a sample edge, so forward the new bit.
                        if (edge_idx == LAST_EDGE) begin
                            state    <= DONE;
                            rx_valid <= 1'b1;
                            rx_data  <= sample_now ? rx_next : rx_shift;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cs_n = '1;
        if (state != IDLE) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (sel_q == SEL_WIDTH'(i)) cs_n[i] = 1'b0;
            end
        end
    end

    assign nextstate = (state == XFER);
    assign busy      = (state != IDLE);
    assign mosi      = ((state == SETUP) || (state == XFER)) ? tx_shift[DATA_WIDTH-1] : 1'b0;
    assign fsm_state = state;

endmodule
